// File: rtl/click_decoder.sv
// +-----------------------------------------------------------------------------+
// | click_decoder: classifies button activity as single/double/triple/long.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module click_decoder #(
  parameter int GAP_CYCLES  = 25000000,
  parameter int LONG_CYCLES = 100000000,
  parameter int TW          = 27
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          press,
  input  logic          held,
  output logic          single_click,
  output logic          double_click,
  output logic          triple_click,
  output logic          long_press,
  output logic          busy,
  output logic [1:0]    click_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    GAP     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [TW-1:0] C_LONG_LAST = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] C_GAP_LAST  = TW'(GAP_CYCLES - 1);

  state_t          r_state;
  logic [TW-1:0]   r_timer;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      click_cnt    <= 2'd0;
      busy         <= 1'b0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      triple_click <= 1'b0;
      long_press   <= 1'b0;
    end else begin
      single_click <= 1'b0;
      double_click <= 1'b0;
      triple_click <= 1'b0;
      long_press   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (press) begin
            r_state   <= HOLD;
            click_cnt <= 2'd1;
            r_timer   <= '0;
            busy      <= 1'b1;
          end
        end

        HOLD: begin
          if (held) begin
            // Only the first press of a sequence may become a long press;
            // later presses just park the timer at the threshold.
            if (click_cnt == 2'd1 && r_timer == C_LONG_LAST) begin
              long_press <= 1'b1;
              r_state    <= RELEASE;
            end else if (r_timer != C_LONG_LAST) begin
              r_timer <= r_timer + 1'b1;
            end
          end else if (click_cnt == 2'd3) begin
            triple_click <= 1'b1;
            r_state      <= IDLE;
            click_cnt    <= 2'd0;
            r_timer      <= '0;
            busy         <= 1'b0;
          end else begin
            r_state <= GAP;
            r_timer <= '0;
          end
        end

        GAP: begin
          // A press on the expiry cycle extends the sequence instead of closing it.
          if (press) begin
            click_cnt <= click_cnt + 2'd1;
            r_state   <= HOLD;
            r_timer   <= '0;
          end else if (r_timer == C_GAP_LAST) begin
            single_click <= (click_cnt == 2'd1);
            double_click <= (click_cnt == 2'd2);
            r_state      <= IDLE;
            click_cnt    <= 2'd0;
            r_timer      <= '0;
            busy         <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        RELEASE: begin
          if (!held) begin
            r_state   <= IDLE;
            click_cnt <= 2'd0;
            r_timer   <= '0;
            busy      <= 1'b0;
          end
        end

        default: begin
          r_state   <= IDLE;
          click_cnt <= 2'd0;
          r_timer   <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_click_decoder.sv
// +-----------------------------------------------------------------------------+
// | tb_click_decoder: scoreboard bench for click_decoder (GAP=10, LONG=20).     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_click_decoder;

  localparam int GAP  = 10;
  localparam int LONG = 20;

  localparam int K_SINGLE = 0;
  localparam int K_DOUBLE = 1;
  localparam int K_TRIPLE = 2;
  localparam int K_LONG   = 3;

  logic       clk;
  logic       reset;
  logic       press;
  logic       held;
  logic       single_click;
  logic       double_click;
  logic       triple_click;
  logic       long_press;
  logic       busy;
  logic [1:0] click_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int cyc;
    int kind;
  } exp_t;

  exp_t exp_q[$];

  click_decoder #(
    .GAP_CYCLES  (GAP),
    .LONG_CYCLES (LONG),
    .TW          (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .press        (press),
    .held         (held),
    .single_click (single_click),
    .double_click (double_click),
    .triple_click (triple_click),
    .long_press   (long_press),
    .busy         (busy),
    .click_cnt    (click_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every pulse seen mid-cycle must match the head of the queue.
  always @(negedge clk) begin
    int n;
    int kind;
    exp_t e;
    n = int'(single_click) + int'(double_click) + int'(triple_click) + int'(long_press);
    if (n > 0) begin
      checks++;
      kind = single_click ? K_SINGLE : double_click ? K_DOUBLE :
             triple_click ? K_TRIPLE : K_LONG;
      if (n > 1) begin
        errors++;
        $display("FAIL multi_pulse cyc=%0d got s%b d%b t%b l%b want at most one",
                 cyc, single_click, double_click, triple_click, long_press);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got kind %0d want none", cyc, kind);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc !== cyc || e.kind !== kind) begin
          errors++;
          $display("FAIL pulse cyc/kind got %0d/%0d want %0d/%0d", cyc, kind, e.cyc, e.kind);
        end
      end
    end
  end

  task automatic tick(input logic p, input logic h);
    press = p;
    held  = h;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_test();
    reset = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic expect_pulse(input int c, input int k);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_pulses got %0d outstanding want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_state(input string name, input logic b, input logic [1:0] cnt);
    checks++;
    if (busy !== b || click_cnt !== cnt) begin
      errors++;
      $display("FAIL %s cyc=%0d got busy=%b cnt=%0d want busy=%b cnt=%0d",
               name, cyc, busy, click_cnt, b, cnt);
    end
  endtask

  task automatic test_reset();
    press = 1'b1;
    held  = 1'b1;
    start_test();
    checks++;
    if ({single_click, double_click, triple_click, long_press, busy, click_cnt} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000000",
               {single_click, double_click, triple_click, long_press, busy, click_cnt});
    end
  endtask

  task automatic test_single();
    start_test();
    expect_pulse(16, K_SINGLE);
    for (int c = 0; c < 24; c++) begin
      if (c == 1)  check_state("single_c1", 1'b1, 2'd1);
      if (c == 15) check_state("single_c15", 1'b1, 2'd1);
      if (c == 16) check_state("single_c16", 1'b0, 2'd0);
      tick(c == 0, c <= 4);
    end
    check_drained("single");
  endtask

  task automatic test_double();
    start_test();
    expect_pulse(23, K_DOUBLE);
    for (int c = 0; c < 28; c++) begin
      if (c >= 9 && c <= 22) check_state("double_cnt2", 1'b1, 2'd2);
      if (c == 23) check_state("double_c23", 1'b0, 2'd0);
      tick(c == 0 || c == 8, c <= 3 || (c >= 8 && c <= 11));
    end
    check_drained("double");
  endtask

  task automatic test_triple();
    start_test();
    expect_pulse(18, K_TRIPLE);
    for (int c = 0; c < 32; c++) begin
      if (c == 15) check_state("triple_c15", 1'b1, 2'd3);
      if (c == 18) check_state("triple_c18", 1'b0, 2'd0);
      tick(c == 0 || c == 7 || c == 14,
           c <= 2 || (c >= 7 && c <= 9) || (c >= 14 && c <= 16));
    end
    check_drained("triple");
  endtask

  task automatic test_long();
    start_test();
    expect_pulse(21, K_LONG);
    for (int c = 0; c < 46; c++) begin
      if (c == 30) check_state("long_release", 1'b1, 2'd1);
      if (c == 40) check_state("long_c40", 1'b1, 2'd1);
      if (c == 41) check_state("long_idle", 1'b0, 2'd0);
      tick(c == 0 || c == 25, c <= 39);
    end
    check_drained("long");
  endtask

  // Release on the very cycle the long threshold is reached: release wins.
  task automatic test_long_boundary();
    start_test();
    expect_pulse(31, K_SINGLE);
    for (int c = 0; c < 36; c++) begin
      if (c == 21) check_state("longb_gap", 1'b1, 2'd1);
      tick(c == 0, c <= 19);
    end
    check_drained("long_boundary");
  endtask

  task automatic test_press_at_expiry();
    start_test();
    expect_pulse(25, K_DOUBLE);
    for (int c = 0; c < 30; c++) begin
      if (c == 13) check_state("expiry_cnt2", 1'b1, 2'd2);
      tick(c == 0 || c == 12, c <= 1 || (c >= 12 && c <= 13));
    end
    check_drained("press_at_expiry");
  endtask

  task automatic test_reset_mid();
    start_test();
    expect_pulse(24, K_SINGLE);
    for (int c = 0; c < 30; c++) begin
      if (c == 9) check_state("rmid_gap", 1'b1, 2'd2);
      if (c == 11) begin
        checks++;
        if ({single_click, double_click, triple_click, long_press, busy, click_cnt} !== 7'd0) begin
          errors++;
          $display("FAIL reset_mid_outputs got %b want 0000000",
                   {single_click, double_click, triple_click, long_press, busy, click_cnt});
        end
      end
      if (c == 12) check_state("rmid_accept", 1'b1, 2'd1);
      reset = (c == 10);
      tick(c == 0 || c == 5 || c == 11, c <= 1 || (c >= 5 && c <= 6) || (c >= 11 && c <= 12));
    end
    reset = 1'b0;
    check_drained("reset_mid");
  endtask

  task automatic test_back_to_back();
    start_test();
    expect_pulse(13, K_SINGLE);
    expect_pulse(26, K_SINGLE);
    for (int c = 0; c < 32; c++) begin
      if (c == 14) check_state("b2b_second", 1'b1, 2'd1);
      tick(c == 0 || c == 13, c <= 1 || (c >= 13 && c <= 14));
    end
    check_drained("back_to_back");
  endtask

  initial begin
    reset = 1'b1;
    press = 1'b0;
    held  = 1'b0;
    test_reset();
    test_single();
    test_double();
    test_triple();
    test_long();
    test_long_boundary();
    test_press_at_expiry();
    test_reset_mid();
    test_back_to_back();
    tick(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
